cic_interp_hs: RTL and testbench



---
 rtl/cic_interp_hs.sv | 109 ++++++++++
 tb/tb_cic_interp_hs.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp_hs.sv
// cic_interp_hs: CIC interpolator with a valid/ready input handshake, differential delay M
// and exact unity DC gain. Define CIC_ROUND_EN to round half-up before the output shift;
// when CIC_ROUND_EN is undefined the output is truncated toward minus infinity.
module cic_interp_hs #(
    parameter int unsigned BIT_WIDTH  = 4,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned RATE       = 8,
    parameter int unsigned DIFF_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 underrun,
    input  logic                 underrun_clr
);
    localparam int unsigned PHASE_W   = $clog2(RATE);
    localparam int unsigned GROWTH    = STAGES * $clog2(RATE * DIFF_DELAY);
    localparam int unsigned INT_WIDTH = BIT_WIDTH + GROWTH;
    localparam int unsigned SHIFT     = GROWTH - PHASE_W;
`ifdef CIC_ROUND_EN
    localparam int unsigned RND_INT = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
`else
    localparam int unsigned RND_INT = 0;
`endif
    localparam logic signed [INT_WIDTH-1:0] RND = INT_WIDTH'(RND_INT);

    typedef logic signed [INT_WIDTH-1:0] acc_t;

    logic [PHASE_W-1:0] phase_q;
    acc_t               last_x_q;
    acc_t               dly_q   [STAGES][DIFF_DELAY];
    acc_t               integ_q [STAGES];
    acc_t               dly_in  [STAGES];
    acc_t               x;
    acc_t               comb_acc;
    acc_t               stuff;
    acc_t               out_sum;
    logic               slot;

    assign slot     = enable && (phase_q == '0);
    assign in_ready = slot && !rst;

    // Input select, comb chain and zero stuffing; the comb result only matters in slot cycles.
    always_comb begin
        x        = in_valid ? {{GROWTH{in_data[BIT_WIDTH-1]}}, in_data} : last_x_q;
        comb_acc = x;
        for (int k = 0; k < STAGES; k++) begin
            dly_in[k] = comb_acc;
            comb_acc  = comb_acc - dly_q[k][DIFF_DELAY-1];
        end
        stuff   = slot ? comb_acc : '0;
        out_sum = integ_q[STAGES-1] + RND;
    end

    // Datapath state: phase, comb delays, held sample, integrators and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= '0;
            last_x_q <= '0;
            out_data <= '0;
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= '0;
                for (int j = 0; j < DIFF_DELAY; j++) begin
                    dly_q[k][j] <= '0;
                end
            end
        end else if (enable) begin
            // RATE is a power of two, so the counter wraps from RATE-1 to 0 by itself.
            phase_q    <= phase_q + PHASE_W'(1);
            integ_q[0] <= integ_q[0] + stuff;
            for (int k = 1; k < STAGES; k++) begin
                integ_q[k] <= integ_q[k] + integ_q[k-1];
            end
            out_data <= BIT_WIDTH'(out_sum >>> SHIFT);
            if (slot) begin
                if (in_valid) begin
                    last_x_q <= x;
                end
                for (int k = 0; k < STAGES; k++) begin
                    dly_q[k][0] <= dly_in[k];
                    for (int j = 1; j < DIFF_DELAY; j++) begin
                        dly_q[k][j] <= dly_q[k][j-1];
                    end
                end
            end
        end
    end

    // out_valid follows enable one edge late; a fresh underrun wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            out_valid <= enable;
            if (slot && !in_valid) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_interp_hs.sv
// Self-checking bench for cic_interp_hs. The reference treats the CIC as a zero-stuffed input
// filtered by the N-fold convolution of a length R*M boxcar, scaled by 2^-SHIFT.
module tb_cic_interp_hs;
    localparam int BW    = 4;
    localparam int N     = 3;
    localparam int R     = 8;
    localparam int M     = 1;
    localparam int SHIFT = N * $clog2(R * M) - $clog2(R);
    localparam int L     = N * (R * M - 1) + 1;
`ifdef CIC_ROUND_EN
    localparam longint RND = (SHIFT > 0) ? (longint'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
`else
    localparam longint RND = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, enable, in_valid, underrun_clr;
    logic [BW-1:0] in_data, out_data;
    logic          in_ready, out_valid, underrun;
    logic [3:0]    s_in_data, s_out_data;
    logic          s_in_valid, s_in_ready, s_out_valid, s_underrun;

    always #5 clk = ~clk;

    cic_interp_hs #(
        .BIT_WIDTH(BW), .STAGES(N), .RATE(R), .DIFF_DELAY(M)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .underrun(underrun), .underrun_clr(underrun_clr)
    );

    cic_interp_hs #(
        .BIT_WIDTH(4), .STAGES(2), .RATE(4), .DIFF_DELAY(1)
    ) dut_step (
        .clk(clk), .rst(rst), .enable(enable), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid),
        .underrun(s_underrun), .underrun_clr(1'b0)
    );

    // Reference model state
    longint        h [L];
    longint        u [$];
    longint        held;
    int            e;
    logic          m_und, exp_valid, exp_ready, obs_ready;
    logic [BW-1:0] exp_out;
    int            n_checks = 0;
    int            n_fail   = 0;

    // Impulse response: N-fold convolution of a boxcar of length R*M.
    function automatic void build_h();
        longint tmp [L];
        int     len;
        for (int i = 0; i < L; i++) h[i] = 0;
        h[0] = 1;
        len  = 1;
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < L; i++) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < R * M; j++) tmp[i+j] += h[i];
            len += R * M - 1;
            h = tmp;
        end
    endfunction

    // Drive one cycle, advance the model across the edge, land on the following negedge.
    task automatic tick(input logic r, input logic en, input logic v, input logic [BW-1:0] d,
                        input logic clr);
        logic   slot;
        longint y;
        longint q;
        int     m;
        rst = r; enable = en; in_valid = v; in_data = d; underrun_clr = clr;
        exp_ready = en && !r && (e % R == 0);
        #1 obs_ready = in_ready;
        if (r) begin
            e = 0; u.delete(); held = 0; m_und = 1'b0; exp_out = '0; exp_valid = 1'b0;
        end else begin
            exp_valid = en;
            slot = en && (e % R == 0);
            if (slot && v) held = longint'($signed(d));
            if (slot && !v) m_und = 1'b1;
            else if (clr) m_und = 1'b0;
            if (en) begin
                u.push_back(slot ? held : 0);
                m = e - N;
                y = 0;
                for (int k = 0; k < L; k++) if (m - k >= 0) y += h[k] * u[m-k];
                q = (y + RND) >>> SHIFT;
                exp_out = q[BW-1:0];
                e++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 1'b1, BW'($urandom), 1'b0);
            n_checks++; if (out_data !== '0) begin n_fail++;
                $display("FAIL reset_out_data: got %h want 0", out_data); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++;
                $display("FAIL reset_out_valid: got %b want 0", out_valid); end
            n_checks++; if (underrun !== 1'b0) begin n_fail++;
                $display("FAIL reset_underrun: got %b want 0", underrun); end
            n_checks++; if (obs_ready !== 1'b0) begin n_fail++;
                $display("FAIL reset_in_ready: got %b want 0", obs_ready); end
        end
        tick(1'b0, 1'b1, 1'b1, '0, 1'b0);
        n_checks++; if (obs_ready !== 1'b1) begin n_fail++;
            $display("FAIL ready_after_reset: got %b want 1", obs_ready); end
    endtask

    task automatic test_step();
        logic [3:0] step_exp [11];
`ifdef CIC_ROUND_EN
        step_exp = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
`else
        step_exp = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
`endif
        s_in_valid = 1'b1;
        s_in_data  = 4'd3;
        tick(1'b1, 1'b1, 1'b1, '0, 1'b0);
        for (int k = 0; k < 11; k++) begin
            if (k == 0) begin
                rst = 1'b0; #1;
                n_checks++; if (s_in_ready !== 1'b1) begin n_fail++;
                    $display("FAIL step_ready: got %b want 1", s_in_ready); end
            end
            tick(1'b0, 1'b1, 1'b1, BW'($urandom), 1'b0);
            n_checks++; if (s_out_data !== step_exp[k]) begin n_fail++;
                $display("FAIL step_out[%0d]: got %0d want %0d", k, s_out_data, step_exp[k]); end
        end
        n_checks++; if (s_out_valid !== 1'b1 || s_underrun !== 1'b0) begin n_fail++;
            $display("FAIL step_flags: got valid=%b underrun=%b want 1/0", s_out_valid, s_underrun);
        end
        s_in_valid = 1'b0;
    endtask

    task automatic test_full_scale();
        logic [BW-1:0] val;
        tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
        for (int p = 0; p < 2; p++) begin
            val = (p == 0) ? 4'h8 : 4'h7;
            for (int i = 0; i < 96; i++) begin
                tick(1'b0, 1'b1, 1'b1, val, 1'b0);
                n_checks++; if (out_data !== exp_out) begin n_fail++;
                    $display("FAIL dc_out[%0d]: got %h want %h", i, out_data, exp_out); end
                n_checks++; if (obs_ready !== exp_ready) begin n_fail++;
                    $display("FAIL dc_ready[%0d]: got %b want %b", i, obs_ready, exp_ready); end
            end
            n_checks++; if (out_data !== val) begin n_fail++;
                $display("FAIL dc_settle: got %h want %h", out_data, val); end
        end
    endtask

    task automatic test_underrun();
        logic v, clr;
        tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 80; i++) begin
            v   = (i != 64) && (i != 72);
            clr = (i == 66) || (i == 72);
            tick(1'b0, 1'b1, v, 4'd5, clr);
            n_checks++; if (underrun !== m_und) begin n_fail++;
                $display("FAIL und_flag[%0d]: got %b want %b", i, underrun, m_und); end
            n_checks++; if (out_data !== exp_out) begin n_fail++;
                $display("FAIL und_out[%0d]: got %h want %h", i, out_data, exp_out); end
            if (i == 64 || i == 72) begin
                n_checks++; if (underrun !== 1'b1 || out_data !== 4'd5) begin n_fail++;
                    $display("FAIL und_set[%0d]: got und=%b out=%0d want 1/5", i, underrun,
                             out_data); end
            end
            if (i == 66) begin
                n_checks++; if (underrun !== 1'b0) begin n_fail++;
                    $display("FAIL und_clear: got %b want 0", underrun); end
            end
        end
    endtask

    task automatic test_enable_gaps();
        logic en;
        tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 3) != 0);
            tick(1'b0, en, 1'b1, BW'(e / R), 1'b0);
            n_checks++; if (out_data !== exp_out) begin n_fail++;
                $display("FAIL gap_out[%0d]: got %h want %h", i, out_data, exp_out); end
            n_checks++; if (out_valid !== exp_valid) begin n_fail++;
                $display("FAIL gap_valid[%0d]: got %b want %b", i, out_valid, exp_valid); end
            if (!en) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++;
                    $display("FAIL gap_valid_low[%0d]: got %b want 0", i, out_valid); end
            end
        end
    endtask

    task automatic test_random();
        logic r, en, v, clr;
        tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 500; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 4) != 0);
            v   = ($urandom_range(0, 6) != 0);
            clr = ($urandom_range(0, 9) == 0);
            tick(r, en, v, BW'($urandom), clr);
            n_checks++; if (out_data !== exp_out) begin n_fail++;
                $display("FAIL rnd_out[%0d]: got %h want %h", i, out_data, exp_out); end
            n_checks++; if (out_valid !== exp_valid) begin n_fail++;
                $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, exp_valid); end
            n_checks++; if (underrun !== m_und) begin n_fail++;
                $display("FAIL rnd_underrun[%0d]: got %b want %b", i, underrun, m_und); end
            n_checks++; if (obs_ready !== exp_ready) begin n_fail++;
                $display("FAIL rnd_ready[%0d]: got %b want %b", i, obs_ready, exp_ready); end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0; underrun_clr = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0;
        e = 0; held = 0; m_und = 1'b0; exp_out = '0; exp_valid = 1'b0;
        build_h();
        @(negedge clk);
        test_reset();
        test_step();
        test_full_scale();
        test_underrun();
        test_enable_gaps();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
